// File: rtl/fp16_em_adder.sv
// Four-register pipelined adder for unsigned 5-bit-exponent / 11-bit-mantissa floats.
// Stages: align -> add -> normalize -> round/saturate into the output registers.
module fp16_em_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] sum,
    output logic        overflow
);

    // Stage 1: swap, align, zero bypass
    logic [4:0]  ea, eb, big_e, small_e, diff;
    logic [10:0] big_m, small_m;
    logic [25:0] wide;
    logic [11:0] al_sig;
    logic        al_g, al_r, al_s, a_zero, b_zero;
    logic [15:0] byp_val;

    always_comb begin
        ea      = a[15:11];
        eb      = b[15:11];
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        big_e   = ea;
        big_m   = a[10:0];
        small_e = eb;
        small_m = b[10:0];
        if (eb > ea) begin
            big_e   = eb;
            big_m   = b[10:0];
            small_e = ea;
            small_m = a[10:0];
        end
        diff = big_e - small_e;
        wide = {1'b1, small_m, 14'b0} >> diff;
        if (diff >= 5'd14) begin
            al_sig = '0;
            al_g   = 1'b0;
            al_r   = 1'b0;
            al_s   = 1'b1;
        end else begin
            al_sig = wide[25:14];
            al_g   = wide[13];
            al_r   = wide[12];
            al_s   = |wide[11:0];
        end
        byp_val = a_zero ? (b_zero ? 16'h0000 : b) : a;
    end

    logic        v1, v2, v3;
    logic [4:0]  e1, e2;
    logic [11:0] big1, sm1;
    logic        g1, r1, s1, g2, r2, s2;
    logic        byp1, byp2, byp3;
    logic [15:0] bv1, bv2, bv3;
    logic [12:0] sum2;
    logic [5:0]  e3;
    logic [11:0] sig3;
    logic        g3, rs3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk) begin
        e1   <= big_e;
        big1 <= {1'b1, big_m};
        sm1  <= al_sig;
        g1   <= al_g;
        r1   <= al_r;
        s1   <= al_s;
        byp1 <= a_zero | b_zero;
        bv1  <= byp_val;

        // Stage 2: add
        e2   <= e1;
        sum2 <= {1'b0, big1} + {1'b0, sm1};
        g2   <= g1;
        r2   <= r1;
        s2   <= s1;
        byp2 <= byp1;
        bv2  <= bv1;

        // Stage 3: a carry-out shifts right once, the dropped bit becomes the new guard
        byp3 <= byp2;
        bv3  <= bv2;
        if (sum2[12]) begin
            e3   <= {1'b0, e2} + 6'd1;
            sig3 <= sum2[12:1];
            g3   <= sum2[0];
            rs3  <= g2 | r2 | s2;
        end else begin
            e3   <= {1'b0, e2};
            sig3 <= sum2[11:0];
            g3   <= g2;
            rs3  <= r2 | s2;
        end
    end

    // Stage 4: round to nearest even, saturate
    logic        round_up, ovf;
    logic [12:0] rnd;
    logic [5:0]  e_fin;
    logic [10:0] man_fin;

    always_comb begin
        round_up = g3 & (rs3 | sig3[0]);
        rnd      = {1'b0, sig3} + {12'b0, round_up};
        if (rnd[12]) begin
            e_fin   = e3 + 6'd1;
            man_fin = '0;
        end else begin
            e_fin   = e3;
            man_fin = rnd[10:0];
        end
        ovf = (e_fin > 6'd31);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                if (byp3) begin
                    sum      <= bv3;
                    overflow <= 1'b0;
                end else begin
                    sum      <= ovf ? 16'hFFFF : {e_fin[4:0], man_fin};
                    overflow <= ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp16_em_adder.sv
// Scoreboard bench for fp16_em_adder: directed vectors plus a randomized stream
// checked against an exact-integer reference model.
module tb_fp16_em_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic [15:0] sum;
    logic        overflow;

    fp16_em_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .sum(sum), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] res;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n_out = 0;
    logic        rst_d = 1'b1;
    logic        started = 1'b0;
    logic [15:0] last_sum = '0;
    logic        last_ovf = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Exact sum of the two scaled integers, then round to 12 significant bits.
    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        longint unsigned s, kept, rem, half;
        int p, er;
        if (x[15:11] == 0) return (y[15:11] == 0) ? 17'h0 : {1'b0, y};
        if (y[15:11] == 0) return {1'b0, x};
        s = (longint'({1'b1, x[10:0]}) << x[15:11]) + (longint'({1'b1, y[10:0]}) << y[15:11]);
        p = 0;
        for (int i = 0; i < 64; i++) if (s[i]) p = i;
        er   = p - 11;
        kept = s >> er;
        rem  = s & ((64'd1 << er) - 1);
        half = 64'd1 << (er - 1);
        if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        if (kept == 64'd4096) begin
            kept = 64'd2048;
            er   = er + 1;
        end
        if (er > 31) return {1'b1, 16'hFFFF};
        return {1'b0, er[4:0], kept[10:0]};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            if (rst_d) begin
                chk("reset_state", {15'b0, out_valid, sum, overflow}, 32'h0);
                last_sum = '0;
                last_ovf = 1'b0;
            end else if (out_valid) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("stale_output", {15'b0, out_valid, sum}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", {16'b0, sum}, {16'b0, e.res[15:0]});
                    chk("overflow", {31'b0, overflow}, {31'b0, e.res[16]});
                    chk("latency", cyc - e.c, 4);
                    last_sum = e.res[15:0];
                    last_ovf = e.res[16];
                end
            end else begin
                chk("hold", {15'b0, overflow, sum}, {15'b0, last_ovf, last_sum});
            end
        end
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [16:0] res);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = x;
        b = y;
        e.res = res;
        e.c   = cyc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle(1);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] x, y;
        int          out_before;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        issue(16'b00101_10101010101, 16'b01010_01000000001, {1'b0, 16'b01010_01001101100});
        idle(5);
        issue(16'b11001_00011111111, 16'b01001_00100100000, {1'b0, 16'b11001_00011111111});
        issue(16'b01011_10001000000, 16'b00100_10001111111, {1'b0, 16'b01011_10001011001});
        issue(16'b01111_00000000000, 16'b01111_00000000000, {1'b0, 16'b10000_00000000000});
        issue(16'b01111_11111111111, 16'b01111_11111111111, {1'b0, 16'b10000_11111111111});
        issue(16'hFFFF, 16'hFFFF, {1'b1, 16'hFFFF});
        issue(16'h0000, 16'b00100_10001111111, {1'b0, 16'b00100_10001111111});
        issue(16'b00100_10001111111, 16'h0000, {1'b0, 16'b00100_10001111111});
        issue(16'h07FF, 16'h0123, {1'b0, 16'h0000});
        issue(16'b00011_00000000001, 16'b00001_00000000011, {1'b0, 16'b00011_01000000010});
        issue(16'b00011_00000000011, 16'b00001_00000000010, {1'b0, 16'b00011_01000000100});
        idle(1);
        drain();

        issue(16'b00101_10101010101, 16'b01010_01000000001, {1'b0, 16'b01010_01001101100});
        issue(16'b11001_00011111111, 16'b01001_00100100000, {1'b0, 16'b11001_00011111111});
        issue(16'b01011_10001000000, 16'b00100_10001111111, {1'b0, 16'b01011_10001011001});
        idle(1);
        drain();

        for (int i = 0; i < 60; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 3 == 0) y[15:11] = x[15:11] - 5'($urandom_range(0, 3));
            if (i % 11 == 0) x[15:11] = 5'd31;
            issue(x, y, ref_add(x, y));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        drain();

        // In-flight operations and the op presented on the reset edge are discarded.
        issue(16'b00101_10101010101, 16'b01010_01000000001, {1'b0, 16'b01010_01001101100});
        issue(16'b11001_00011111111, 16'b01001_00100100000, {1'b0, 16'b11001_00011111111});
        issue(16'b01011_10001000000, 16'b00100_10001111111, {1'b0, 16'b01011_10001011001});
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'b01111_00000000000;
        b        = 16'b01111_00000000000;
        exp_q.delete();
        out_before = n_out;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        idle(8);
        chk("post_reset_outputs", n_out - out_before, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
